hazard_fwd_unit: RTL and testbench

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_fwd_unit_fwd_select.sv | 28 ++
 rtl/hazard_fwd_unit.sv | 153 +++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding unit: FSM state encoding and
// the width of the forwarding-mux select.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    function automatic int sel_w(input int num_stages);
        return $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_select.sv
// Forwarding priority search for one EX operand: returns k+1 for the
// nearest writing stage whose destination matches, 0 for the regfile.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int REG_AW     = 5,
    parameter int SEL_W      = sel_w(NUM_STAGES)
) (
    input  logic [REG_AW-1:0]            rs,
    input  logic [NUM_STAGES*REG_AW-1:0] stg_rd,
    input  logic [NUM_STAGES-1:0]        stg_wb,
    output logic [SEL_W-1:0]             sel
);

    // Walk from the farthest stage inward so the nearest match overwrites.
    always_comb begin
        sel = '0;
        if (rs != '0) begin
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (stg_wb[k] && (stg_rd[k*REG_AW +: REG_AW] == rs)) begin
                    sel = SEL_W'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard unit: operand forwarding, load-use bubbles, data-memory
// wait stalls with a sticky timeout, and a saturating stall-cycle counter.
//
// state    | meaning
// RUN      | normal flow; load-use hazards insert one bubble
// MEM_WAIT | data memory response outstanding; whole front end frozen
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter  int NUM_FWD_STAGES = 2,
    parameter  int REG_AW         = 5,
    parameter  int MAX_WAIT       = 15,
    parameter  int CNT_W          = 16,
    localparam int SEL_W          = sel_w(NUM_FWD_STAGES)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [REG_AW-1:0]                id_rs1,
    input  logic [REG_AW-1:0]                id_rs2,
    input  logic                             id_use_rs1,
    input  logic                             id_use_rs2,
    input  logic [REG_AW-1:0]                ex_rs1,
    input  logic [REG_AW-1:0]                ex_rs2,
    input  logic [REG_AW-1:0]                ex_rd,
    input  logic                             ex_reg_write,
    input  logic                             ex_mem_read,
    input  logic [NUM_FWD_STAGES*REG_AW-1:0] stg_rd,
    input  logic [NUM_FWD_STAGES-1:0]        stg_wb,
    input  logic                             mem_load,
    input  logic                             mem_ready,
    output logic [SEL_W-1:0]                 fwd_a,
    output logic [SEL_W-1:0]                 fwd_b,
    output logic                             stall_if,
    output logic                             stall_id,
    output logic                             stall_ex,
    output logic                             stall_mem,
    output logic                             flush_ex,
    output logic                             mem_timeout,
    output logic [CNT_W-1:0]                 stall_cnt
);

    localparam int               WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [SEL_W-1:0]    sel_a, sel_b;
    logic                load_use;

    fwd_select #(
        .NUM_STAGES (NUM_FWD_STAGES),
        .REG_AW     (REG_AW),
        .SEL_W      (SEL_W)
    ) u_fwd_a (
        .rs     (ex_rs1),
        .stg_rd (stg_rd),
        .stg_wb (stg_wb),
        .sel    (sel_a)
    );

    fwd_select #(
        .NUM_STAGES (NUM_FWD_STAGES),
        .REG_AW     (REG_AW),
        .SEL_W      (SEL_W)
    ) u_fwd_b (
        .rs     (ex_rs2),
        .stg_rd (stg_rd),
        .stg_wb (stg_wb),
        .sel    (sel_b)
    );

    assign fwd_a = rst_n ? sel_a : '0;
    assign fwd_b = rst_n ? sel_b : '0;

    assign load_use = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        stall_if      = 1'b0;
        stall_id      = 1'b0;
        stall_ex      = 1'b0;
        stall_mem     = 1'b0;
        flush_ex      = 1'b0;

        case (state_q)
            RUN: begin
                // A pending memory wait freezes everything, so no bubble is needed.
                if (mem_load && !mem_ready) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    stall_mem = 1'b1;
                    state_d   = MEM_WAIT;
                end else if (load_use) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else begin
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    stall_ex   = 1'b1;
                    stall_mem  = 1'b1;
                    wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        if (wait_cnt_d == WAIT_MAX) begin
            mem_timeout_d = 1'b1;
        end

        if (!rst_n) begin
            stall_if  = 1'b0;
            stall_id  = 1'b0;
            stall_ex  = 1'b0;
            stall_mem = 1'b0;
            flush_ex  = 1'b0;
        end

        stall_cnt_d = (stall_if && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: behavioural model checked every
// cycle plus directed vectors with hand-computed expectations.
module tb_hazard_fwd_unit;

    localparam int NFS = 3;
    localparam int AW  = 5;
    localparam int MW  = 4;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic            id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read;
    logic [NFS*AW-1:0] stg_rd;
    logic [NFS-1:0]  stg_wb;
    logic            mem_load, mem_ready;
    logic [1:0]      fwd_a, fwd_b;
    logic            stall_if, stall_id, stall_ex, stall_mem, flush_ex, mem_timeout;
    logic [CW-1:0]   stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_fwd_unit #(
        .NUM_FWD_STAGES (NFS),
        .REG_AW         (AW),
        .MAX_WAIT       (MW),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .stg_rd       (stg_rd),
        .stg_wb       (stg_wb),
        .mem_load     (mem_load),
        .mem_ready    (mem_ready),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .stall_ex     (stall_ex),
        .stall_mem    (stall_mem),
        .flush_ex     (flush_ex),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: which pipeline stage (1-based) supplies register rs, 0 = regfile.
    function automatic int fwd_model(input logic [AW-1:0] rs);
        if (rs == 0) return 0;
        for (int k = 0; k < NFS; k++) begin
            if (stg_wb[k] && stg_rd[k*AW +: AW] == rs) return k + 1;
        end
        return 0;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Model state: waiting on memory, cycles waited, timeout seen, stall total.
    bit m_wait = 0, n_wait = 0;
    int m_cnt = 0, n_cnt = 0;
    bit m_to = 0, n_to = 0;
    int m_total = 0, n_total = 0;
    int e_fa, e_fb;
    bit e_hold, e_bub, lu;

    always @(negedge clk) begin
        if (!rst_n) begin
            e_fa = 0; e_fb = 0; e_hold = 0; e_bub = 0;
            n_wait = 0; n_cnt = 0; n_to = 0; n_total = 0;
        end else begin
            e_fa = fwd_model(ex_rs1);
            e_fb = fwd_model(ex_rs2);
            lu = ex_mem_read && ex_reg_write && ex_rd != 0 &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
            e_hold = !mem_ready && (m_wait || mem_load);
            e_bub  = !m_wait && !e_hold && lu;
            n_wait = e_hold;
            n_cnt  = (m_wait && !mem_ready) ? min_i(m_cnt + 1, MW) : 0;
            n_to   = m_to || (n_cnt == MW);
            n_total = min_i(m_total + ((e_hold || e_bub) ? 1 : 0), SAT);
        end
        chk("fwd_a", fwd_a, e_fa);
        chk("fwd_b", fwd_b, e_fb);
        chk("stall_if", stall_if, e_hold || e_bub);
        chk("stall_id", stall_id, e_hold || e_bub);
        chk("stall_ex", stall_ex, e_hold);
        chk("stall_mem", stall_mem, e_hold);
        chk("flush_ex", flush_ex, e_bub);
        chk("mem_timeout", mem_timeout, rst_n ? m_to : 0);
        chk("stall_cnt", stall_cnt, rst_n ? m_total : 0);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait <= 0; m_cnt <= 0; m_to <= 0; m_total <= 0;
        end else begin
            m_wait <= n_wait; m_cnt <= n_cnt; m_to <= n_to; m_total <= n_total;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        stg_rd = 0; stg_wb = 0; mem_load = 0; mem_ready = 0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    endtask

    initial begin
        idle();
        rst_n  = 0;
        ex_rs1 = 5;
        stg_rd = {5'd5, 5'd5, 5'd5};
        stg_wb = 3'b111;
        @(negedge clk);
        chk("lit_rst_fwd_a", fwd_a, 0);
        chk("lit_rst_stall_cnt", stall_cnt, 0);

        // Stage priority
        tick(); rst_n = 1; stg_wb = 3'b110;
        @(negedge clk); chk("lit_prio_110", fwd_a, 2);
        tick(); stg_wb = 3'b111;
        @(negedge clk); chk("lit_prio_111", fwd_a, 1);
        tick(); stg_wb = 3'b100; ex_rs2 = 5;
        @(negedge clk); chk("lit_prio_100_b", fwd_b, 3);

        // x0 never matches
        tick(); idle(); stg_wb = 3'b001;
        @(negedge clk); chk("lit_x0_fwd_b", fwd_b, 0);
        tick(); idle(); ex_mem_read = 1; ex_reg_write = 1; id_use_rs1 = 1;
        @(negedge clk); chk("lit_x0_no_stall", stall_if, 0);

        // Load-use bubble
        tick(); idle(); set_load_use();
        @(negedge clk);
        chk("lit_lu_stall_if", stall_if, 1);
        chk("lit_lu_flush", flush_ex, 1);
        chk("lit_lu_stall_ex", stall_ex, 0);
        chk("lit_lu_cnt0", stall_cnt, 0);
        tick(); idle();
        @(negedge clk);
        chk("lit_lu_cnt1", stall_cnt, 1);
        chk("lit_lu_one_cycle", stall_if, 0);

        // Memory wait overlapping a load-use hazard
        for (int i = 0; i < 3; i++) begin
            tick(); idle(); set_load_use(); mem_load = 1;
            @(negedge clk);
            chk("lit_mw_stall_mem", stall_mem, 1);
            chk("lit_mw_no_flush", flush_ex, 0);
        end
        tick(); mem_ready = 1;
        @(negedge clk); chk("lit_mw_release", stall_if, 0);
        tick(); mem_load = 0; mem_ready = 0;
        @(negedge clk);
        chk("lit_lu_after_release", flush_ex, 1);
        chk("lit_cnt4", stall_cnt, 4);
        tick(); idle();
        @(negedge clk); chk("lit_cnt5", stall_cnt, 5);

        // Timeout after MW wait cycles, sticky across release
        tick(); mem_load = 1;
        for (int w = 1; w <= 5; w++) begin
            tick();
            @(negedge clk);
            if (w == 4) chk("lit_to_before", mem_timeout, 0);
            if (w == 5) chk("lit_to_set", mem_timeout, 1);
        end
        tick(); mem_ready = 1;
        @(negedge clk);
        chk("lit_to_ready", mem_timeout, 1);
        chk("lit_to_release", stall_if, 0);
        tick(); idle();
        @(negedge clk);
        chk("lit_to_sticky", mem_timeout, 1);
        chk("lit_cnt11", stall_cnt, 11);

        // Stall counter saturation
        tick(); mem_load = 1;
        repeat (7) tick();
        @(negedge clk); chk("lit_cnt_sat", stall_cnt, SAT);

        // Reset in the middle of a wait
        tick(); rst_n = 0;
        @(negedge clk);
        chk("lit_rstw_stall_if", stall_if, 0);
        chk("lit_rstw_stall_mem", stall_mem, 0);
        chk("lit_rstw_cnt", stall_cnt, 0);
        chk("lit_rstw_to", mem_timeout, 0);
        tick(); rst_n = 1; mem_load = 0; mem_ready = 0;
        @(negedge clk);
        chk("lit_rstw_run_if", stall_if, 0);
        chk("lit_rstw_run_mem", stall_mem, 0);
        tick();
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
